// File: rtl/regffte_pingpong.sv
// -----------------------------------------------------------------------------
// regffte_pingpong
//
// Double-buffered (ping-pong) register file for the MFCC datapath. A producer
// streams frames of energy words sequentially into the write bank while the
// consumer randomly reads the previously completed frame from the read bank.
// Banks swap under a full/release handshake, so the producer can never
// overwrite a frame that the consumer has not yet released.
//
// Parameters
//   DATA_W  word width
//   ADDR_W  address width
//   DEPTH   maximum words per frame, 2 <= DEPTH <= 2**ADDR_W
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   wr_en          write request
//   wr_data        write word
//   wr_last        final word of a frame (qualified by wr_en)
//   wr_ready       write bank can accept a word
//   overflow       sticky: a write arrived while wr_ready was low
//   rd_valid       a completed frame is available in the read bank
//   rd_len         word count of the frame in the read bank
//   rd_en          read request
//   rd_addr        read address within the read bank
//   rd_data        registered read data (1-cycle latency)
//   rd_data_valid  rd_data holds the result of a read issued last cycle
//   rd_done        releases the read bank
// -----------------------------------------------------------------------------
module regffte_pingpong #(
  parameter int DATA_W = 39,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              overflow,
  output logic              rd_valid,
  output logic [ADDR_W:0]   rd_len,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              rd_done
);

  // Write counter value at which a frame closes without wr_last.
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              wb;          // bank currently being written
  logic              rb;          // bank currently offered for reading
  logic [1:0]        full;        // bank holds a completed, unreleased frame
  logic [ADDR_W:0]   wr_ptr;      // next write position in the write bank
  logic [ADDR_W:0]   len [2];     // latched frame length per bank

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake decode (all from registered state plus qualifying inputs)
  // ---------------------------------------------------------------------------
  logic              wr_accept;
  logic              wr_complete;
  logic              rd_fire;
  logic              rd_release;
  logic              rd_in_range;
  logic [DATA_W-1:0] rd_word;

  assign wr_ready = ~full[wb];
  assign rd_valid = full[rb];
  assign rd_len   = len[rb];

  assign wr_accept   = wr_en & wr_ready;
  // A frame closes on wr_last or when the bank runs out of space; if both
  // happen on the same word it still closes exactly once, with len = DEPTH.
  assign wr_complete = wr_accept & (wr_last | (wr_ptr == LAST_PTR));

  assign rd_fire     = rd_en & rd_valid;
  assign rd_release  = rd_done & rd_valid;
  // Addresses beyond the frame return zero rather than stale bank contents.
  assign rd_in_range = {1'b0, rd_addr} < len[rb];

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = rb ? mem1[rd_addr] : mem0[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the banks have no reset so they map onto plain RAM/register arrays;
  // nothing can read a word before it has been written because len gates reads.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      if (wb) begin
        mem1[wr_ptr[ADDR_W-1:0]] <= wr_data;
      end else begin
        mem0[wr_ptr[ADDR_W-1:0]] <= wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every decision in a
  // cycle sees the pre-edge values of wb/rb/full (e.g. a read issued with a
  // release still uses the old rb).
  always_ff @(posedge clk) begin
    if (rst) begin
      wb            <= 1'b0;
      rb            <= 1'b0;
      full          <= 2'b00;
      wr_ptr        <= '0;
      len[0]        <= '0;
      len[1]        <= '0;
      overflow      <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      if (wr_en & ~wr_ready) begin
        overflow <= 1'b1;
      end

      // Completion and release never target the same bank: completion needs
      // full[wb]=0 and release needs full[rb]=1, so both updates can coexist.
      if (wr_complete) begin
        len[wb]  <= wr_ptr + 1'b1;
        full[wb] <= 1'b1;
        wb       <= ~wb;
        wr_ptr   <= '0;
      end else if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (rd_release) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end

      rd_data_valid <= rd_fire;
      if (rd_fire) begin
        rd_data <= rd_word;
      end
    end
  end

endmodule

// File: doc/regffte_pingpong.md
# regffte_pingpong

Parametrised double-buffered register file for the MFCC datapath. Frames of square-root/FFT energy words are written sequentially into one bank while the previously completed bank is randomly read by the filterbank stage. Banks swap automatically under a full/release handshake. It replaces single-bank, unprotected read/write storage with frame-level flow control, variable frame length and overflow detection.

## Interface

**Parameters**
- DATA_W, 39, word width.
- ADDR_W, 6, address width.
- DEPTH, 64, maximum words per frame; must satisfy 2 <= DEPTH <= 2**ADDR_W.

**Ports**
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- wr_last  in  1  marks the final word of a frame (qualified by wr_en).
- wr_ready  out  1  write bank can accept a word.
- overflow  out  1  sticky; set when wr_en is high while wr_ready is low.
- rd_valid  out  1  a completed frame is available in the read bank.
- rd_len  out  ADDR_W+1  word count of the frame in the read bank.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address within the read bank.
- rd_data  out  DATA_W  registered read data.
- rd_data_valid  out  1  rd_data is valid this cycle.
- rd_done  in  1  releases the read bank.

## Operation

- Storage is two banks of DEPTH x DATA_W. State comprises:
  - write-bank pointer wb and read-bank pointer rb (1 bit each);
  - full[1:0] flags;
  - write counter wr_ptr (ADDR_W+1 bits);
  - a latched length len[b] for each bank.
- wr_ready = !full[wb].
- **Accepted write** (wr_en & wr_ready): mem[wb][wr_ptr] <= wr_data; wr_ptr increments.
- **Frame completion** occurs on an accepted write with wr_last=1, or when wr_ptr == DEPTH-1. On completion:
  - len[wb] <= wr_ptr+1;
  - full[wb] <= 1;
  - wb toggles;
  - wr_ptr <= 0.
- **Rejected write** (wr_en & !wr_ready): data is dropped, wr_ptr is unchanged, and overflow sets. overflow clears only on rst.
- rd_valid = full[rb]; rd_len = len[rb].
- **Read** (rd_en & rd_valid): rd_data <= mem[rb][rd_addr] and rd_data_valid <= 1 on the next cycle.
  - If rd_addr >= len[rb], rd_data <= 0 and rd_data_valid is still asserted.
- rd_en while !rd_valid: ignored. rd_data holds its value and rd_data_valid <= 0.
- **Release** (rd_done & rd_valid): full[rb] <= 0 and rb toggles. rd_done while !rd_valid is ignored.
- **Simultaneous events**:
  - rd_en and rd_done in the same cycle: the read uses the pre-release rb; its data appears on the next cycle as normal.
  - Frame completion into bank X and release of bank Y in the same cycle: both take effect.
  - Completion and release on the same bank cannot occur, because a full bank accepts no writes.
- A frame of exactly DEPTH words, or with wr_last on word DEPTH-1, completes once with len = DEPTH.
- Order is preserved: frames are read in the order written. rb always follows wb.
- **Reset**:
  - wb, rb, full, wr_ptr, len and overflow clear to 0;
  - rd_data clears to 0 and rd_data_valid to 0;
  - wr_ready = 1 and rd_valid = 0 on the cycle after rst;
  - memory contents are not cleared;
  - a partially written frame is discarded, and a pending read result from the reset cycle is suppressed.

## Timing

- Write: accepted on the edge where wr_en & wr_ready. Back-to-back writes sustain 1 word/cycle.
- rd_valid rises on the cycle after the completing write's edge.
- wr_ready falls on the cycle after completion only if the other bank is still full.
- Read latency is exactly 1 cycle (rd_en at edge N gives rd_data/rd_data_valid during cycle N+1). Back-to-back reads sustain 1 word/cycle.
- After a release, rd_valid reflects the other bank on the next cycle, and wr_ready rises on the next cycle if it was low.
- All outputs are registered or decoded directly from registered state. There is no combinational path from any input to any output.

## Test plan

- **Reset and default-config fill:** rst 1 cycle, then write 64 words 0..63 with no wr_last. Expect wr_ready=1 throughout and rd_valid=1 with rd_len=64 one cycle after word 63. Reading addresses 0..63 back-to-back returns 0..63, each with 1-cycle latency.
- **Short frame and out-of-range read:** 10 words with wr_last on the 10th. Expect rd_len=10. A read of addr 5 returns word 5; a read of addr 12 returns 0 with rd_data_valid=1.
- **Backpressure and overflow:** write two full frames without rd_done. Expect wr_ready=0 after the second completion, and a third wr_en sets overflow=1. rd_done then gives wr_ready=1 and rd_valid=1 with the second frame's data on the next cycle.
- **Simultaneous events:** rd_en, rd_done and a completing write all in one cycle. Expect read data from the old bank on the next cycle, the banks swapped, and no lost frame.
- **Reset mid-operation:** assert rst after 20 words of a frame with one full frame pending. Expect rd_valid=0, wr_ready=1, overflow=0 and rd_data_valid=0. A new 4-word frame then reads back correctly with len=4.
- **Parametrisation:** DATA_W=16, ADDR_W=3, DEPTH=8. Repeat the fill and backpressure tests, with auto-completion at the 8th word.
